// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight and buffers words in a prefetch FIFO.
// Define FETCH_FIELDS_EN to add decoded field outputs (opcode/rs/rt/imm/sign-extended imm) from the FIFO head.
module instruction_fetch #(
  parameter int                  PC_WIDTH   = 8,
  parameter int                  INST_WIDTH = 8,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  sysclk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [PC_WIDTH-1:0]   if_pc
`ifdef FETCH_FIELDS_EN
  ,
  output logic [2:0]            if_opcode,
  output logic                  if_rs,
  output logic                  if_rt,
  output logic [2:0]            if_imm,
  output logic [7:0]            if_signext_imm
`endif
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                state;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  discard;
  logic [PC_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];

  logic                  ack;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      count_next;
  logic [PC_WIDTH-1:0]   ack_pc;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    ack_pc = fetch_pc + PC_WIDTH'(1);
    if (discard) ack_pc = fetch_pc;
    ack        = imem_req & imem_ack;
    push       = ack & ~discard & ~redirect_valid;
    pop        = if_valid & if_ready;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  assign if_valid = (count != '0);
  assign if_inst  = if_valid ? inst_mem[rd_ptr] : '0;
  assign if_pc    = if_valid ? pc_mem[rd_ptr]   : '0;

`ifdef FETCH_FIELDS_EN
  // if_inst is already zero while empty, so the fields inherit that.
  assign if_opcode      = if_inst[7:5];
  assign if_rs          = if_inst[4];
  assign if_rt          = if_inst[3];
  assign if_imm         = if_inst[2:0];
  assign if_signext_imm = {{5{if_inst[2]}}, if_inst[2:0]};
`endif

  // NOTE: buffer storage has no reset; if_valid masks stale entries, so only pointers and count are reset.
  always_ff @(posedge sysclk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= imem_addr;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      discard   <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect_valid) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc;
      if (imem_req && !imem_ack) begin
        // The in-flight request must still complete; its data is dropped on arrival.
        discard <= 1'b1;
      end else if (ack) begin
        discard   <= 1'b0;
        state     <= REQ;
        imem_req  <= 1'b1;
        imem_addr <= redirect_pc;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      case (state)
        IDLE: begin
          if (count < DEPTH_C) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc <= ack_pc;
            discard  <= 1'b0;
            // A new request reserves a slot, so only continue while one is free.
            if (count_next < DEPTH_C) begin
              imem_addr <= ack_pc;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
